// File: rtl/round_arbiter.sv
// round_arbiter: shares one combinational rounder between NUM_REQ FPU
// producers. A round-robin grant picks one valid request, its operands are
// registered and presented to the rounder for a single cycle, and the rounded
// result is held until the writeback stage takes it. The dynamic rounding
// mode (rm == 3'b111) is resolved from fcsr.frm at the moment of acceptance.
module round_arbiter #(
  parameter int NUM_REQ = 2,  // 2..4; pointer and source index are 2 bits
  parameter int TAG_W   = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_sign,
  input  logic [NUM_REQ*8-1:0]     req_exp,
  input  logic [NUM_REQ*25-1:0]    req_frac,
  input  logic [NUM_REQ*3-1:0]     req_frm,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic [2:0]               csr_frm,
  output logic [2:0]               rnd_frm,
  output logic                     rnd_sign,
  output logic [7:0]               rnd_exp,
  output logic [24:0]              rnd_frac,
  input  logic [31:0]              rnd_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [1:0]               out_src,
  output logic                     out_nx,
  output logic                     out_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Canonical quiet NaN returned when the resolved rounding mode is reserved.
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  state_t state, state_nxt;

  logic [1:0]       rr_ptr;
  logic [1:0]       rr_ptr_nxt;
  logic [3:0]       valid_pad;
  logic [2:0]       cand;
  logic [1:0]       grant_idx;
  logic             grant_found;
  logic             accept_win;
  logic             accept;

  logic             sel_sign;
  logic [7:0]       sel_exp;
  logic [24:0]      sel_frac;
  logic [2:0]       sel_frm;
  logic [2:0]       sel_frm_res;
  logic [TAG_W-1:0] sel_tag;

  logic             op_sign;
  logic [7:0]       op_exp;
  logic [24:0]      op_frac;
  logic [2:0]       op_frm;
  logic [TAG_W-1:0] op_tag;
  logic [1:0]       op_src;
  logic             op_illegal;

  // Pad the valid vector to 4 bits so the rotating index is always in range.
  assign valid_pad = 4'(req_valid);

  // Round-robin search: walk offsets from far to near so the nearest valid
  // requester at or after rr_ptr is the one that sticks.
  always_comb begin
    grant_idx   = rr_ptr;
    grant_found = 1'b0;
    cand        = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'(NUM_REQ)) begin
        cand = cand - 3'(NUM_REQ);
      end
      if (valid_pad[cand[1:0]]) begin
        grant_idx   = cand[1:0];
        grant_found = 1'b1;
      end
    end
  end

  // A new request may enter when nothing is in flight, or when the held
  // result is being taken this very cycle (back-to-back hand-over).
  assign accept_win = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept     = accept_win && grant_found;

  // Pointer moves to the requester just after the one that won.
  assign rr_ptr_nxt = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;

  // Ready is a one-hot decode of the grant, gated only by the accept window.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant_idx == 2'(i));
    end
  end

  // Operand mux: pick the granted requester's fields out of the packed buses.
  always_comb begin
    sel_sign = 1'b0;
    sel_exp  = 8'd0;
    sel_frac = 25'd0;
    sel_frm  = 3'd0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_sign = req_sign[i];
        sel_exp  = req_exp[8*i +: 8];
        sel_frac = req_frac[25*i +: 25];
        sel_frm  = req_frm[3*i +: 3];
        sel_tag  = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  // Dynamic mode takes fcsr.frm as it stands in the accepting cycle only.
  assign sel_frm_res = (sel_frm == 3'b111) ? csr_frm : sel_frm;

  // Modes 101, 110 and 111 (after resolution) have no defined rounding.
  assign op_illegal = (op_frm >= 3'b101);

  // Next-state logic: BUSY always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = accept ? BUSY : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture and round-robin pointer update on every accept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr  <= 2'd0;
      op_sign <= 1'b0;
      op_exp  <= 8'd0;
      op_frac <= 25'd0;
      op_frm  <= 3'd0;
      op_tag  <= '0;
      op_src  <= 2'd0;
    end else if (accept) begin
      rr_ptr  <= rr_ptr_nxt;
      op_sign <= sel_sign;
      op_exp  <= sel_exp;
      op_frac <= sel_frac;
      op_frm  <= sel_frm_res;
      op_tag  <= sel_tag;
      op_src  <= grant_idx;
    end
  end

  // Result capture at the end of the BUSY cycle; held until the next one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_result  <= 32'd0;
      out_tag     <= '0;
      out_src     <= 2'd0;
      out_nx      <= 1'b0;
      out_illegal <= 1'b0;
    end else if (state == BUSY) begin
      out_result  <= op_illegal ? CANON_NAN : rnd_out;
      out_tag     <= op_tag;
      out_src     <= op_src;
      out_nx      <= !op_illegal && (op_frac[1:0] != 2'b00);
      out_illegal <= op_illegal;
    end
  end

  assign rnd_sign  = op_sign;
  assign rnd_exp   = op_exp;
  assign rnd_frac  = op_frac;
  assign rnd_frm   = op_frm;
  assign out_valid = (state == DONE);

endmodule
